// File: rtl/fifo_rd_agent_if.sv
// rtl/fifo_rd_agent_if.sv - downstream word stream between the FIFO read agent and its consumer
interface fifo_rd_agent_if #(
  parameter int WIDTH   = 32,
  parameter int ERRDATA = 6
);
  logic               m_valid;
  logic               m_ready;
  logic [WIDTH-1:0]   m_data;
  logic               m_peek;
  logic               m_corrected;
  logic [ERRDATA-1:0] m_err_idx;

  modport master (
    output m_valid,
    output m_data,
    output m_peek,
    output m_corrected,
    output m_err_idx,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_peek,
    input  m_corrected,
    input  m_err_idx,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_agent.sv
// rtl/fifo_rd_agent.sv - read-side agent for the ECC-protected sync FIFO
// Saturating error statistics are built only when FIFO_RD_ERR_STAT_EN is defined.
module fifo_rd_agent #(
  parameter int WIDTH   = 32,
  parameter int ERRDATA = 6,
  parameter int ERRPTR  = 4,
  parameter int RD_LAT  = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pop_req,
  input  logic               peek_req,
  input  logic [2:0]         fifo_status,
  input  logic [WIDTH-1:0]   fifo_out_reg,
  input  logic [ERRDATA-1:0] data_err_idx_reg,
  input  logic [ERRPTR-1:0]  rd_ptr_err_idx_reg,
  input  logic [ERRPTR-1:0]  wr_ptr_err_idx_reg,
  output logic               arbiter_rd_en,
  output logic               arbiter_rd_only,
  output logic               req_ack,
  output logic               busy,
  fifo_rd_agent_if.master    m_if,
  output logic [CNT_W-1:0]   data_err_cnt,
  output logic [CNT_W-1:0]   ptr_err_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  logic [1:0]         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               type_peek_q, type_peek_d;
  logic               req_ack_q, req_ack_d;
  logic               rd_en_q, rd_en_d;
  logic               rd_only_q, rd_only_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [ERRDATA-1:0] err_idx_q, err_idx_d;
  logic               corrected_q, corrected_d;
  logic               out_peek_q, out_peek_d;
  logic               capture;
  logic               req_any;

  assign req_any = pop_req | peek_req;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    type_peek_d = type_peek_q;
    req_ack_d   = 1'b0;
    rd_en_d     = 1'b0;
    rd_only_d   = 1'b0;
    valid_d     = valid_q;
    data_d      = data_q;
    err_idx_d   = err_idx_q;
    corrected_d = corrected_q;
    out_peek_d  = out_peek_q;
    capture     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Outputs are registered, so ack and read enable are raised on the way into ISSUE.
        if (req_any && (fifo_status != 3'd0)) begin
          state_d     = ST_ISSUE;
          req_ack_d   = 1'b1;
          rd_en_d     = 1'b1;
          rd_only_d   = ~pop_req;
          type_peek_d = ~pop_req;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = LAT;
      end
      ST_WAIT: begin
        if (cnt_q == 3'd1) begin
          capture     = 1'b1;
          cnt_d       = 3'd0;
          data_d      = fifo_out_reg;
          err_idx_d   = data_err_idx_reg;
          corrected_d = (data_err_idx_reg != '0);
          out_peek_d  = type_peek_q;
          valid_d     = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_HOLD: begin
        if (valid_q && m_if.m_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      type_peek_q <= 1'b0;
      req_ack_q   <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_only_q   <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      err_idx_q   <= '0;
      corrected_q <= 1'b0;
      out_peek_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      type_peek_q <= type_peek_d;
      req_ack_q   <= req_ack_d;
      rd_en_q     <= rd_en_d;
      rd_only_q   <= rd_only_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      err_idx_q   <= err_idx_d;
      corrected_q <= corrected_d;
      out_peek_q  <= out_peek_d;
    end
  end

  assign arbiter_rd_en    = rd_en_q;
  assign arbiter_rd_only  = rd_only_q;
  assign req_ack          = req_ack_q;
  assign busy             = busy_q;
  assign m_if.m_valid     = valid_q;
  assign m_if.m_data      = data_q;
  assign m_if.m_peek      = out_peek_q;
  assign m_if.m_corrected = corrected_q;
  assign m_if.m_err_idx   = err_idx_q;

`ifdef FIFO_RD_ERR_STAT_EN
  localparam int              SW  = CNT_W + 1;
  localparam logic [CNT_W:0]  SAT = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [1:0]       ptr_inc;
  logic [CNT_W:0]   dsum;
  logic [CNT_W:0]   psum;

  // Sums are one bit wider than the counters so an overflow can be clamped instead of wrapping.
  always_comb begin
    ptr_inc = {1'b0, (rd_ptr_err_idx_reg != '0)} + {1'b0, (wr_ptr_err_idx_reg != '0)};
    dsum    = {1'b0, dcnt_q} + SW'(data_err_idx_reg != '0);
    psum    = {1'b0, pcnt_q} + SW'(ptr_inc);
    dcnt_d  = (dsum > SAT) ? SAT[CNT_W-1:0] : dsum[CNT_W-1:0];
    pcnt_d  = (psum > SAT) ? SAT[CNT_W-1:0] : psum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_q <= '0;
      pcnt_q <= '0;
    end else if (capture) begin
      dcnt_q <= dcnt_d;
      pcnt_q <= pcnt_d;
    end
  end

  assign data_err_cnt = dcnt_q;
  assign ptr_err_cnt  = pcnt_q;
`else
  logic unused_stat_inputs;

  assign unused_stat_inputs = ^{rd_ptr_err_idx_reg, wr_ptr_err_idx_reg, capture};
  assign data_err_cnt       = '0;
  assign ptr_err_cnt        = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_agent.sv
// tb/tb_fifo_rd_agent.sv - scoreboard bench for fifo_rd_agent against a timing-rule reference model
module tb_fifo_rd_agent;

  localparam int WIDTH   = 32;
  localparam int ERRDATA = 6;
  localparam int ERRPTR  = 4;
  localparam int RD_LAT  = 2;
  localparam int CNT_W   = 2;
  localparam int CMAX    = (1 << CNT_W) - 1;

  typedef struct {
    logic [WIDTH-1:0]   d;
    logic [ERRDATA-1:0] e;
    bit                 pk;
    int                 dc;
    int                 pc;
  } item_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               pop_req = 1'b0;
  logic               peek_req = 1'b0;
  logic [2:0]         fifo_status = 3'd0;
  logic [WIDTH-1:0]   fifo_out_reg = '0;
  logic [ERRDATA-1:0] data_err_idx_reg = '0;
  logic [ERRPTR-1:0]  rd_ptr_err_idx_reg = '0;
  logic [ERRPTR-1:0]  wr_ptr_err_idx_reg = '0;
  logic               m_ready = 1'b0;
  logic               arbiter_rd_en;
  logic               arbiter_rd_only;
  logic               req_ack;
  logic               busy;
  logic [CNT_W-1:0]   data_err_cnt;
  logic [CNT_W-1:0]   ptr_err_cnt;

  fifo_rd_agent_if #(.WIDTH(WIDTH), .ERRDATA(ERRDATA)) m_if ();
  assign m_if.m_ready = m_ready;

  fifo_rd_agent #(
    .WIDTH(WIDTH), .ERRDATA(ERRDATA), .ERRPTR(ERRPTR), .RD_LAT(RD_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .pop_req            (pop_req),
    .peek_req           (peek_req),
    .fifo_status        (fifo_status),
    .fifo_out_reg       (fifo_out_reg),
    .data_err_idx_reg   (data_err_idx_reg),
    .rd_ptr_err_idx_reg (rd_ptr_err_idx_reg),
    .wr_ptr_err_idx_reg (wr_ptr_err_idx_reg),
    .arbiter_rd_en      (arbiter_rd_en),
    .arbiter_rd_only    (arbiter_rd_only),
    .req_ack            (req_ack),
    .busy               (busy),
    .m_if               (m_if),
    .data_err_cnt       (data_err_cnt),
    .ptr_err_cnt        (ptr_err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // reference model state: one transaction at a time, described by its cycle numbers
  bit    in_tx = 1'b0;
  bit    peek_m = 1'b0;
  int    ack_cyc = -100;
  int    valid_cyc = -100;
  int    word_cyc = -100;
  int    rst_cyc = -100;
  int    acks = 0;
  item_t sb[$];
  item_t cur;

  int               dcnt_m = 0;
  int               pcnt_m = 0;
  bit               force_en = 1'b0;
  logic [WIDTH-1:0] force_d;
  logic [5:0]       force_e;
  logic [3:0]       force_rp;
  logic [3:0]       force_wp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout_%s at cycle %0d: got no event expected one", name, cyc);
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // FIFO side: the read word appears RD_LAT cycles after the read-enable cycle; garbage otherwise
  task automatic drive_fifo();
    item_t it;
    if (cyc == word_cyc) begin
      if (force_en) begin
        fifo_out_reg       = force_d;
        data_err_idx_reg   = force_e;
        rd_ptr_err_idx_reg = force_rp;
        wr_ptr_err_idx_reg = force_wp;
        force_en           = 1'b0;
      end else begin
        fifo_out_reg       = $urandom;
        data_err_idx_reg   = ($urandom % 2 == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
        rd_ptr_err_idx_reg = ($urandom % 4 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        wr_ptr_err_idx_reg = ($urandom % 4 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      end
      dcnt_m = sat(dcnt_m + ((data_err_idx_reg != 0) ? 1 : 0));
      pcnt_m = sat(pcnt_m + ((rd_ptr_err_idx_reg != 0) ? 1 : 0) + ((wr_ptr_err_idx_reg != 0) ? 1 : 0));
      it.d  = fifo_out_reg;
      it.e  = data_err_idx_reg;
      it.pk = peek_m;
`ifdef FIFO_RD_ERR_STAT_EN
      it.dc = dcnt_m;
      it.pc = pcnt_m;
`else
      it.dc = 0;
      it.pc = 0;
`endif
      sb.push_back(it);
    end else begin
      fifo_out_reg       = $urandom;
      data_err_idx_reg   = 6'($urandom);
      rd_ptr_err_idx_reg = 4'($urandom);
      wr_ptr_err_idx_reg = 4'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_fifo();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    dcnt_m = 0;
    pcnt_m = 0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic wait_ack();
    int  a0 = acks;
    bit  got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      if (acks != a0) got = 1'b1;
    end
    if (!got) timeout("ack");
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      if (!in_tx) done = 1'b1;
    end
    if (!done) timeout("idle");
  endtask

  task automatic request(input bit p, input bit k);
    pop_req  = p;
    peek_req = k;
    wait_ack();
    pop_req  = 1'b0;
    peek_req = 1'b0;
  endtask

  // monitor: compares DUT outputs with the model, then advances the model for the next cycle
  always @(negedge clk) begin
    bit act_now;
    bit exp_v;
    if (cyc >= 1) begin
      act_now = in_tx && (cyc == ack_cyc);
      exp_v   = in_tx && (cyc >= valid_cyc);
      check("req_ack", req_ack, act_now);
      check("rd_en", arbiter_rd_en, act_now);
      check("rd_only", arbiter_rd_only, act_now && peek_m);
      check("busy", busy, in_tx);
      check("m_valid", m_if.m_valid, exp_v);
      if (exp_v && cyc == valid_cyc) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard at cycle %0d: got valid word expected none queued", cyc);
        end else begin
          cur = sb.pop_front();
          check("m_data", m_if.m_data, cur.d);
          check("m_err_idx", m_if.m_err_idx, cur.e);
          check("m_corrected", m_if.m_corrected, cur.e != 0);
          check("m_peek", m_if.m_peek, cur.pk);
          check("data_err_cnt", data_err_cnt, cur.dc);
          check("ptr_err_cnt", ptr_err_cnt, cur.pc);
        end
      end else if (exp_v) begin
        check("m_data_hold", m_if.m_data, cur.d);
        check("m_err_idx_hold", m_if.m_err_idx, cur.e);
      end
      if (cyc == rst_cyc + 1) begin
        check("data_err_cnt_rst", data_err_cnt, 0);
        check("ptr_err_cnt_rst", ptr_err_cnt, 0);
      end

      if (rst) begin
        in_tx    = 1'b0;
        word_cyc = -100;
        rst_cyc  = cyc;
        sb.delete();
      end else if (exp_v && m_ready) begin
        in_tx = 1'b0;
      end else if (!in_tx && (pop_req || peek_req) && fifo_status != 3'd0) begin
        in_tx     = 1'b1;
        peek_m    = !pop_req;
        ack_cyc   = cyc + 1;
        word_cyc  = cyc + 1 + RD_LAT;
        valid_cyc = cyc + 2 + RD_LAT;
        acks++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog at cycle %0d: got no finish expected one", cyc);
    $fatal(1);
  end

  initial begin
    bit seen;
    m_ready = 1'b1;
    do_reset(3);

    // empty FIFO: requests are ignored
    fifo_status = 3'd0;
    pop_req = 1'b1;
    repeat (10) step();
    pop_req = 1'b0;

    // directed pop of DEADBEEF
    fifo_status = 3'd2;
    force_en = 1'b1; force_d = 32'hDEADBEEF; force_e = 6'd0; force_rp = 4'd0; force_wp = 4'd0;
    request(1'b1, 1'b0);
    wait_idle();

    // pop wins over peek, then a peek alone
    request(1'b1, 1'b1);
    wait_idle();
    request(1'b0, 1'b1);
    wait_idle();

    // consumer stall with a pending pop held through HOLD
    m_ready = 1'b0;
    request(1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      if (m_if.m_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) timeout("stall_valid");
    pop_req = 1'b1;
    repeat (5) step();
    m_ready = 1'b1;
    wait_ack();
    pop_req = 1'b0;
    wait_idle();

    // error capture from clean counters, then saturation
    do_reset(2);
    for (int k = 0; k < 4; k++) begin
      force_en = 1'b1; force_d = $urandom; force_e = 6'd7; force_rp = 4'd3; force_wp = 4'd1;
      request(1'b1, 1'b0);
      wait_idle();
    end

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step();
      pop_req     = ($urandom % 4 == 0);
      peek_req    = ($urandom % 4 == 0);
      fifo_status = ($urandom % 5 == 0) ? 3'd0 : 3'($urandom_range(1, 5));
      m_ready     = ($urandom % 4 != 0);
    end
    pop_req = 1'b0;
    peek_req = 1'b0;
    m_ready = 1'b1;
    fifo_status = 3'd3;
    wait_idle();

    // reset while waiting on read latency, then a normal pop
    pop_req = 1'b1;
    wait_ack();
    pop_req = 1'b0;
    step();
    rst = 1'b1;
    dcnt_m = 0;
    pcnt_m = 0;
    step();
    rst = 1'b0;
    request(1'b1, 1'b0);
    wait_idle();

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_agent.md
Name: fifo_rd_agent

Overview:
- Read-side agent for the ECC-protected sync FIFO.
- Drives `arbiter_rd_en` / `arbiter_rd_only` into the FIFO block.
- Waits a fixed read latency, then captures the registered read bank: data, data error index, pointer error indices.
- Presents one word per read to a downstream consumer over a valid/ready handshake. Optionally keeps saturating error statistics.

Parameters:
- WIDTH, 32, data word width
- ERRDATA, 6, data error index width
- ERRPTR, 4, pointer error index width
- RD_LAT, 2, cycles from the `arbiter_rd_en` cycle until `fifo_out_reg` holds the read word; legal range 1..7
- CNT_W, 16, error counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- pop_req  in  1  request: read and pop one word
- peek_req  in  1  request: read head word without popping
- fifo_status  in  3  FIFO fill status: 0=empty … 5=full
- fifo_out_reg  in  WIDTH  corrected read data from the FIFO register bank
- data_err_idx_reg  in  ERRDATA  data error index; 0 = no error
- rd_ptr_err_idx_reg  in  ERRPTR  read pointer error index; 0 = no error
- wr_ptr_err_idx_reg  in  ERRPTR  write pointer error index; 0 = no error
- arbiter_rd_en  out  1  read enable to FIFO
- arbiter_rd_only  out  1  read-without-pop qualifier to FIFO
- req_ack  out  1  one-cycle pulse: request accepted
- busy  out  1  high in any state other than IDLE
- m_valid  out  1  output word valid
- m_ready  in  1  consumer ready
- m_data  out  WIDTH  captured word
- m_peek  out  1  word came from a peek
- m_corrected  out  1  `data_err_idx_reg` was nonzero at capture
- m_err_idx  out  ERRDATA  captured data error index
- data_err_cnt  out  CNT_W  corrected data error count
- ptr_err_cnt  out  CNT_W  pointer error count

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all outputs 0; FSM to IDLE; wait counter 0.
- Output registration: all outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - If `pop_req`|`peek_req` and `fifo_status`!=0, then pulse `req_ack` for one cycle and go to ISSUE.
  - `pop_req` has priority over `peek_req` when both are high; the type is latched.
  - If `fifo_status`==0, requests are ignored: no ack, stay IDLE. Requesters hold the request until `req_ack`.
- ISSUE (exactly 1 cycle):
  - `arbiter_rd_en`=1.
  - `arbiter_rd_only`=1 for peek, 0 for pop.
  - Load the wait counter with RD_LAT; go to WAIT.
- WAIT:
  - `arbiter_rd_en`=0 and `arbiter_rd_only`=0.
  - Decrement the counter each cycle. On the cycle the counter reaches 1, capture:
    - `m_data`<=`fifo_out_reg`
    - `m_err_idx`<=`data_err_idx_reg`
    - `m_corrected`<=(`data_err_idx_reg`!=0)
    - `m_peek`<=latched type
  - Then set `m_valid`=1 and go to HOLD.
- HOLD:
  - `m_valid` stays high and the captured fields stay stable until `m_valid`&`m_ready`.
  - On that handshake: `m_valid`<=0, go to IDLE.
  - New requests are not accepted in HOLD, so the next request can be acked at the earliest on the cycle after the handshake.
- Latency: request sampled in IDLE at cycle N:
  - `req_ack` at N+1.
  - `arbiter_rd_en` at N+1.
  - `m_valid` first high at N+2+RD_LAT (RD_LAT=2 gives N+4).
- Throughput: with `m_ready` tied high, one word per RD_LAT+3 cycles.
- Pop/peek request deasserted after ack: no effect; the transaction completes.
- `fifo_status` changing during WAIT/HOLD: ignored.
- Reset mid-transaction: FSM returns to IDLE and `m_valid` drops the next cycle. An in-flight pop is abandoned; the pointer advance in the FIFO is not undone. The captured word is discarded.
- Error counting (when enabled):
  - At capture, `data_err_cnt`+=1 if `data_err_idx_reg`!=0.
  - At capture, `ptr_err_cnt`+=1 per nonzero pointer index (+0, +1 or +2).
  - Both counters saturate at 2^CNT_W-1; no wrap.

Optional Feature:
- Macro: FIFO_RD_ERR_STAT_EN.
- Defined: the counters `data_err_cnt` and `ptr_err_cnt` are implemented as above and are cleared only by `rst`.
- Undefined: both outputs are tied to 0 and no counter flops are synthesised. All other behaviour is identical.

Test Plan:
- Reset, then `fifo_status`=0, `pop_req`=1 for 10 cycles -> no `req_ack`, `arbiter_rd_en` never high, `busy`=0.
- `fifo_status`=2, `pop_req` at N, `fifo_out_reg`=32'hDEADBEEF valid from N+3, `m_ready`=1 -> `arbiter_rd_en` high only at N+1 with `arbiter_rd_only`=0; `m_valid` at N+4 with `m_data`=DEADBEEF, `m_peek`=0.
- `pop_req` and `peek_req` both high -> pop served (`arbiter_rd_only`=0). Then a peek-only request -> `arbiter_rd_only`=1 during ISSUE and `m_peek`=1.
- `m_ready`=0 for 5 cycles after `m_valid` while `fifo_out_reg` changes -> `m_data` stable; a new `pop_req` is not acked until after the handshake.
- With the macro defined: capture with `data_err_idx_reg`=6'd7, `rd_ptr_err_idx_reg`=4'd3, `wr_ptr_err_idx_reg`=4'd1 -> `m_corrected`=1, `m_err_idx`=7, `data_err_cnt`=1, `ptr_err_cnt`=2. Preload near saturation with CNT_W=2: repeated errors hold at 3.
- `rst` asserted during WAIT -> next cycle `busy`=0, `m_valid`=0, counters 0. A subsequent pop completes normally.
